// File: rtl/weight_fetch_pkg.sv
// rtl/weight_fetch_pkg.sv - shared types, codes and helpers for the weight fetch unit
package weight_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ3  = 2'd1,
    REQ1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] MODE_BOTH = 2'b00;
  localparam logic [1:0] MODE_3X3  = 2'b01;
  localparam logic [1:0] MODE_1X1  = 2'b10;

  localparam logic KIND_3X3 = 1'b0;
  localparam logic KIND_1X1 = 1'b1;

  function automatic int unsigned ceil_words(input int unsigned count, input int unsigned wpw);
    return (count + wpw - 1) / wpw;
  endfunction

endpackage

// File: rtl/wfu_credit_cnt.sv
// rtl/wfu_credit_cnt.sv - outstanding read counter with issue-credit flag
module wfu_credit_cnt #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             can_issue
);

  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (inc && !dec) begin
      count_next = count + CNT_W'(1);
    end else if (dec && !inc) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Looks one cycle ahead so the registered request valid never overshoots the limit
  assign can_issue = count_next < CNT_W'(MAX_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/weight_fetch_unit.sv
// rtl/weight_fetch_unit.sv - fetches 3x3 then 1x1 kernel words for one output channel
module weight_fetch_unit
  import weight_fetch_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WGT_W   = 8,
  parameter int ADDR_W  = 32,
  parameter int CH_W    = 8,
  parameter int IDX_W   = 12,
  parameter int MAX_OUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [CH_W-1:0]        in_ch,
  input  logic [CH_W-1:0]        out_ch_idx,
  input  logic [ADDR_W-1:0]      w3_base,
  input  logic [ADDR_W-1:0]      w1_base,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_W-1:0]      req_addr,
  output logic                   req_vld,
  input  logic                   req_rdy,
  input  logic [DATA_W-1:0]      rsp_data,
  input  logic                   rsp_vld,
  output logic                   rsp_rdy,
  output logic [CH_W+IDX_W:0]    wbuf_waddr,
  output logic [DATA_W-1:0]      wbuf_wdata,
  output logic                   wbuf_wen,
  input  logic                   wbuf_rdy
);

  localparam int unsigned WPW = DATA_W / WGT_W;
  localparam int CNT_W = IDX_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n3, n1, n3_new, n1_new;
  logic [CNT_W-1:0] req_left, req_left_nxt, rsp_cnt, rsp_cnt_nxt;
  logic [CH_W-1:0]  och;
  logic [ADDR_W-1:0] a1, a3_new, a1_new, req_addr_nxt;
  logic             req_vld_nxt, done_nxt;
  logic [OUT_W-1:0] outstanding;
  logic             can_issue, accept, req_hs, rsp_hs, rsp_counted, kind;
  logic [CNT_W-1:0] idx_full;

  assign accept      = start && (state == IDLE);
  assign req_hs      = req_vld && req_rdy;
  assign rsp_hs      = rsp_vld && wbuf_rdy;
  assign rsp_counted = rsp_hs && (outstanding != '0);

  assign busy       = (state != IDLE);
  assign rsp_rdy    = wbuf_rdy;
  assign wbuf_wen   = rsp_counted;
  assign wbuf_wdata = rsp_data;

  wfu_credit_cnt #(.MAX_OUT(MAX_OUT), .CNT_W(OUT_W)) u_credit (
    .clk       (clk),
    .rst       (rst),
    .inc       (req_hs),
    .dec       (rsp_counted),
    .count     (outstanding),
    .can_issue (can_issue)
  );

  always_comb begin
    n3_new = CNT_W'(ceil_words(32'(in_ch) * 32'd9, WPW));
    n1_new = CNT_W'(ceil_words(32'(in_ch), WPW));
    if (mode == MODE_1X1) n3_new = '0;
    if (mode == MODE_3X3) n1_new = '0;
    a3_new = w3_base + ADDR_W'(out_ch_idx) * ADDR_W'(n3_new) * STRIDE;
    a1_new = w1_base + ADDR_W'(out_ch_idx) * ADDR_W'(n1_new) * STRIDE;
  end

  always_comb begin
    kind     = (rsp_cnt >= n3) ? KIND_1X1 : KIND_3X3;
    idx_full = (kind == KIND_1X1) ? (rsp_cnt - n3) : rsp_cnt;
  end
  assign wbuf_waddr = {kind, och, idx_full[IDX_W-1:0]};

  always_comb begin
    state_nxt    = state;
    req_left_nxt = req_left;
    req_addr_nxt = req_addr;
    rsp_cnt_nxt  = rsp_cnt + CNT_W'(rsp_counted);
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          rsp_cnt_nxt  = '0;
          req_addr_nxt = a3_new;
          if (n3_new != '0) begin
            state_nxt    = REQ3;
            req_left_nxt = n3_new;
          end else if (n1_new != '0) begin
            state_nxt    = REQ1;
            req_left_nxt = n1_new;
            req_addr_nxt = a1_new;
          end else begin
            state_nxt    = DRAIN;
            req_left_nxt = '0;
          end
        end
      end
      REQ3, REQ1: begin
        if (req_hs) begin
          req_left_nxt = req_left - CNT_W'(1);
          req_addr_nxt = req_addr + STRIDE;
          if (req_left == CNT_W'(1)) begin
            state_nxt = DRAIN;
            if (state == REQ3) begin
              req_addr_nxt = a1;
              if (n1 != '0) begin
                state_nxt    = REQ1;
                req_left_nxt = n1;
              end
            end
          end
        end
      end
      DRAIN: begin
        if (rsp_cnt_nxt == n3 + n1) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    req_vld_nxt = ((state_nxt == REQ3) || (state_nxt == REQ1)) && (req_left_nxt != '0) && can_issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_left <= '0;
      rsp_cnt  <= '0;
      req_addr <= '0;
      req_vld  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      n3       <= '0;
      n1       <= '0;
      och      <= '0;
      a1       <= '0;
    end else begin
      state    <= state_nxt;
      req_left <= req_left_nxt;
      rsp_cnt  <= rsp_cnt_nxt;
      req_addr <= req_addr_nxt;
      req_vld  <= req_vld_nxt;
      done     <= done_nxt;
      if (accept) begin
        n3  <= n3_new;
        n1  <= n1_new;
        och <= out_ch_idx;
        a1  <= a1_new;
      end
      // A response with nothing outstanding is dropped but flagged
      if (rsp_hs && (outstanding == '0)) begin
        err <= 1'b1;
      end else if (accept) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_weight_fetch_unit.sv
// tb/tb_weight_fetch_unit.sv - scoreboard bench for weight_fetch_unit
module tb_weight_fetch_unit;
  import weight_fetch_pkg::*;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, err;
  logic [1:0]  mode;
  logic [7:0]  in_ch, out_ch_idx;
  logic [31:0] w3_base, w1_base, req_addr, rsp_data, wbuf_wdata;
  logic        req_vld, req_rdy, rsp_vld, rsp_rdy, wbuf_wen, wbuf_rdy;
  logic [20:0] wbuf_waddr;

  always #5 clk = ~clk;

  weight_fetch_unit #(
    .DATA_W(32), .WGT_W(8), .ADDR_W(32), .CH_W(8), .IDX_W(12), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_ch(in_ch),
    .out_ch_idx(out_ch_idx), .w3_base(w3_base), .w1_base(w1_base),
    .busy(busy), .done(done), .err(err), .req_addr(req_addr), .req_vld(req_vld),
    .req_rdy(req_rdy), .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .wbuf_waddr(wbuf_waddr), .wbuf_wdata(wbuf_wdata), .wbuf_wen(wbuf_wen),
    .wbuf_rdy(wbuf_rdy)
  );

  int passed = 0, total = 0;
  int req_seen = 0, done_seen = 0, stall = 0;
  bit mon_en = 1'b0, rsp_en = 1'b1, wbuf_tog = 1'b0, inject = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, mon_a;
  logic [52:0] mon_w;

  logic [31:0] exp_req_q[$];
  logic [31:0] pend_q[$];
  logic [52:0] exp_wr_q[$];

  function automatic logic [31:0] rsp_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  // Bus monitor: handshakes are sampled half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        total++;
        if (req_vld !== 1'b1 || req_addr !== prev_addr)
          $display("FAIL req_hold: vld=%b addr=%h, expected vld=1 addr=%h", req_vld, req_addr, prev_addr);
        else passed++;
      end
      prev_stall = req_vld && !req_rdy;
      prev_addr  = req_addr;
      if (rsp_vld && rsp_rdy && pend_q.size() > 0) mon_a = pend_q.pop_front();
      if (req_vld && req_rdy) begin
        total++;
        if (exp_req_q.size() == 0) begin
          $display("FAIL req_addr: unexpected request at %h, expected none", req_addr);
        end else begin
          mon_a = exp_req_q.pop_front();
          if (req_addr !== mon_a) $display("FAIL req_addr: got %h, expected %h", req_addr, mon_a);
          else passed++;
        end
        pend_q.push_back(req_addr);
        req_seen++;
        total++;
        if (pend_q.size() > MAX_OUT) $display("FAIL outstanding: got %0d, expected <= %0d", pend_q.size(), MAX_OUT);
        else passed++;
      end
      total++;
      if (rsp_rdy !== wbuf_rdy || (wbuf_wen && !wbuf_rdy))
        $display("FAIL wbuf_flow: rsp_rdy=%b wen=%b, expected rsp_rdy=%b and no write while wbuf_rdy=0", rsp_rdy, wbuf_wen, wbuf_rdy);
      else passed++;
      if (wbuf_wen) begin
        total++;
        if (exp_wr_q.size() == 0) begin
          $display("FAIL wbuf_write: unexpected write %h/%h, expected none", wbuf_waddr, wbuf_wdata);
        end else begin
          mon_w = exp_wr_q.pop_front();
          if ({wbuf_waddr, wbuf_wdata} !== mon_w)
            $display("FAIL wbuf_write: got %h/%h, expected %h/%h", wbuf_waddr, wbuf_wdata, mon_w[52:32], mon_w[31:0]);
          else passed++;
        end
      end
      if (done) begin
        done_seen++;
        total++;
        if (busy !== 1'b0) $display("FAIL done_busy: busy=%b with done, expected 0", busy);
        else passed++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
    start   = 1'b0;
    req_rdy = (stall == 0);
    if (stall > 0) stall--;
    if (wbuf_tog) wbuf_rdy = ~wbuf_rdy;
    rsp_vld  = inject || (rsp_en && pend_q.size() > 0);
    rsp_data = (pend_q.size() > 0) ? rsp_of(pend_q[0]) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] ic, input logic [7:0] och,
                        input logic [31:0] w3, input logic [31:0] w1);
    int n3, n1;
    logic [31:0] a3, a1, a;
    logic [11:0] idx;
    n3 = (9 * int'(ic) + 3) / 4;
    n1 = (int'(ic) + 3) / 4;
    if (m == MODE_1X1) n3 = 0;
    if (m == MODE_3X3) n1 = 0;
    a3 = w3 + 32'(och) * 32'(n3) * 32'd4;
    a1 = w1 + 32'(och) * 32'(n1) * 32'd4;
    for (int i = 0; i < n3; i++) begin
      a = a3 + 32'(i) * 32'd4;
      idx = 12'(i);
      exp_req_q.push_back(a);
      exp_wr_q.push_back({KIND_3X3, och, idx, rsp_of(a)});
    end
    for (int i = 0; i < n1; i++) begin
      a = a1 + 32'(i) * 32'd4;
      idx = 12'(i);
      exp_req_q.push_back(a);
      exp_wr_q.push_back({KIND_1X1, och, idx, rsp_of(a)});
    end
    mode = m; in_ch = ic; out_ch_idx = och; w3_base = w3; w1_base = w1;
    start = 1'b1;
  endtask

  task automatic run_to_done(input int bound, output bit ok);
    int d0;
    d0 = done_seen;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step;
      if (done_seen != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || req_vld !== 1'b0 || req_addr !== 32'h0 || wbuf_wen !== 1'b0)
      $display("FAIL reset: busy=%b done=%b err=%b vld=%b addr=%h wen=%b, expected all 0",
               busy, done, err, req_vld, req_addr, wbuf_wen);
    else passed++;
  endtask

  task automatic test_basic;
    int r0, d0;
    bit ok;
    r0 = req_seen; d0 = done_seen;
    launch(MODE_BOTH, 8'd16, 8'd2, 32'h1000, 32'h8000);
    step;
    total++;
    if (req_vld !== 1'b1 || req_addr !== 32'h1120 || busy !== 1'b1)
      $display("FAIL first_req: vld=%b addr=%h busy=%b, expected 1/00001120/1", req_vld, req_addr, busy);
    else passed++;
    run_to_done(400, ok);
    total++;
    if (!ok) $display("FAIL basic_done: no done within bound, expected done");
    else passed++;
    repeat (3) step;
    total++;
    if (req_seen - r0 != 40 || done_seen - d0 != 1 || exp_req_q.size() != 0 || exp_wr_q.size() != 0)
      $display("FAIL basic_counts: reqs=%0d dones=%0d left=%0d/%0d, expected 40/1/0/0",
               req_seen - r0, done_seen - d0, exp_req_q.size(), exp_wr_q.size());
    else passed++;
  endtask

  task automatic test_req_stall;
    int r0;
    bit stalled, ok;
    r0 = req_seen;
    stalled = 1'b0;
    ok = 1'b0;
    launch(MODE_BOTH, 8'd16, 8'd2, 32'h1000, 32'h8000);
    for (int i = 0; i < 400 && !ok; i++) begin
      step;
      if (!stalled && req_seen - r0 >= 10) begin
        stall = 5;
        stalled = 1'b1;
      end
      if (req_seen - r0 == 40 && exp_wr_q.size() == 0 && !busy) ok = 1'b1;
    end
    total++;
    if (!ok || !stalled || exp_req_q.size() != 0)
      $display("FAIL stall_run: reqs=%0d left=%0d, expected 40 reqs, 0 left", req_seen - r0, exp_req_q.size());
    else passed++;
  endtask

  task automatic test_credit_limit;
    int r0;
    bit ok;
    r0 = req_seen;
    rsp_en = 1'b0;
    launch(MODE_BOTH, 8'd16, 8'd2, 32'h1000, 32'h8000);
    repeat (12) step;
    total++;
    if (req_seen - r0 != MAX_OUT || req_vld !== 1'b0)
      $display("FAIL credit_stop: reqs=%0d vld=%b, expected %0d/0", req_seen - r0, req_vld, MAX_OUT);
    else passed++;
    rsp_en = 1'b1;
    run_to_done(400, ok);
    total++;
    if (!ok || req_seen - r0 != 40 || exp_wr_q.size() != 0)
      $display("FAIL credit_run: done=%b reqs=%0d, expected 1/40", ok, req_seen - r0);
    else passed++;
  endtask

  task automatic test_wbuf_backpressure;
    bit ok;
    wbuf_tog = 1'b1;
    launch(MODE_BOTH, 8'd16, 8'd2, 32'h1000, 32'h8000);
    run_to_done(800, ok);
    wbuf_tog = 1'b0;
    wbuf_rdy = 1'b1;
    total++;
    if (!ok || exp_wr_q.size() != 0)
      $display("FAIL wbuf_run: done=%b left=%0d, expected 1/0", ok, exp_wr_q.size());
    else passed++;
  endtask

  task automatic test_1x1_and_empty;
    int r0;
    bit ok;
    r0 = req_seen;
    launch(MODE_1X1, 8'd5, 8'd3, 32'h1000, 32'h8000);
    run_to_done(100, ok);
    total++;
    if (!ok || req_seen - r0 != 2 || exp_wr_q.size() != 0)
      $display("FAIL mode_1x1: done=%b reqs=%0d, expected 1/2", ok, req_seen - r0);
    else passed++;
    step;
    r0 = req_seen;
    launch(MODE_BOTH, 8'd0, 8'd5, 32'h1000, 32'h8000);
    step;
    total++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL empty_c1: done=%b busy=%b, expected 0/1", done, busy);
    else passed++;
    step;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || req_seen != r0)
      $display("FAIL empty_c2: done=%b busy=%b reqs=%0d, expected 1/0/0", done, busy, req_seen - r0);
    else passed++;
    step;
    total++;
    if (done !== 1'b0) $display("FAIL empty_pulse: done=%b, expected 0", done);
    else passed++;
  endtask

  task automatic test_reset_and_err;
    int r0;
    bit ok;
    r0 = req_seen;
    launch(MODE_BOTH, 8'd16, 8'd2, 32'h1000, 32'h8000);
    for (int i = 0; i < 200 && req_seen - r0 < 10; i++) step;
    mon_en = 1'b0;
    rsp_en = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || req_vld !== 1'b0 || req_addr !== 32'h0)
      $display("FAIL mid_reset: busy=%b done=%b err=%b vld=%b addr=%h, expected all 0",
               busy, done, err, req_vld, req_addr);
    else passed++;
    exp_req_q.delete(); exp_wr_q.delete(); pend_q.delete();
    prev_stall = 1'b0;
    mon_en = 1'b1;
    rsp_en = 1'b1;
    inject = 1'b1;
    step;
    total++;
    if (wbuf_wen !== 1'b0 || rsp_rdy !== 1'b1)
      $display("FAIL stray_rsp: wen=%b rsp_rdy=%b, expected 0/1", wbuf_wen, rsp_rdy);
    else passed++;
    inject = 1'b0;
    step;
    total++;
    if (err !== 1'b1) $display("FAIL err_set: err=%b, expected 1", err);
    else passed++;
    step;
    total++;
    if (err !== 1'b1) $display("FAIL err_sticky: err=%b, expected 1", err);
    else passed++;
    launch(MODE_BOTH, 8'd0, 8'd1, 32'h1000, 32'h8000);
    step;
    total++;
    if (err !== 1'b0) $display("FAIL err_clear: err=%b, expected 0", err);
    else passed++;
    run_to_done(10, ok);
    total++;
    if (!ok) $display("FAIL err_done: no done within bound, expected done");
    else passed++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; in_ch = '0; out_ch_idx = '0;
    w3_base = '0; w1_base = '0; req_rdy = 1'b1; rsp_vld = 1'b0; rsp_data = '0; wbuf_rdy = 1'b1;
    repeat (3) step;
    rst = 1'b0;
    step;
    mon_en = 1'b1;
    test_reset;
    test_basic;
    step;
    test_req_stall;
    step;
    test_credit_limit;
    step;
    test_wbuf_backpressure;
    step;
    test_1x1_and_empty;
    step;
    test_reset_and_err;
    repeat (2) step;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
